// File: rtl/mips_pkg.sv
// Shared types for the MIPS front end: fetch FSM states and the IF/ID payload.
// Pure declarations, no logic and no latency.
// Imported by the fetch unit, its next-PC selector and the decode stage.
package mips_pkg;

  typedef enum logic [1:0] {
    BOOT  = 2'b00,
    RUN   = 2'b01,
    FAULT = 2'b10
  } fetch_state_t;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  // IF/ID pipeline register contents as seen by decode.
  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc4;
    logic        valid;
  } ifid_t;

  // Word-aligned fetch targets have both low address bits clear.
  function automatic logic is_misaligned(input logic [31:0] addr);
    return addr[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Bundle between the fetch unit, instruction memory and the later pipeline stages.
// No logic; the memory side is combinational (data valid in the cycle of the address).
// No backpressure on the bus; later stages hold fetch via stall.
interface instr_fetch_unit_if;

  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_target;
  logic        exc_req;
  logic [31:0] ifid_instr;
  logic [31:0] ifid_pc4;
  logic        ifid_valid;
  logic        fetch_fault;
  logic [31:0] fetch_count;
  logic [31:0] redirect_count;

  // Fetch unit side.
  modport master (
    output imem_addr,
    input  imem_data,
    input  stall,
    input  redirect,
    input  redirect_target,
    input  exc_req,
    output ifid_instr,
    output ifid_pc4,
    output ifid_valid,
    output fetch_fault,
    output fetch_count,
    output redirect_count
  );

  // Memory / pipeline environment side.
  modport slave (
    input  imem_addr,
    output imem_data,
    output stall,
    output redirect,
    output redirect_target,
    output exc_req,
    input  ifid_instr,
    input  ifid_pc4,
    input  ifid_valid,
    input  fetch_fault,
    input  fetch_count,
    input  redirect_count
  );

endinterface

// File: rtl/instr_fetch_unit_pc_next_sel.sv
// Next-PC priority mux: exception > misaligned redirect > redirect > stall > sequential.
// Purely combinational, zero latency.
// Stall only suppresses the sequential capture; redirect and exception override it.
module pc_next_sel
  import mips_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR = 32'hF000_0000
) (
  input  fetch_state_t state_i,
  input  logic [31:0]  pc_i,
  input  logic         stall_i,
  input  logic         redirect_i,
  input  logic [31:0]  redirect_target_i,
  input  logic         exc_req_i,
  output fetch_state_t state_d_o,
  output logic [31:0]  pc_d_o,
  output logic [31:0]  pc4_o,
  output logic         capture_o,
  output logic         squash_o,
  output logic         fault_set_o,
  output logic         fault_clr_o,
  output logic         redir_acc_o
);

  // Sequential address wraps naturally at 2^32.
  assign pc4_o = pc_i + 32'd4;

  // Decide next state, next PC and the IF/ID / counter side effects.
  always_comb begin
    state_d_o   = state_i;
    pc_d_o      = pc_i;
    capture_o   = 1'b0;
    squash_o    = 1'b0;
    fault_set_o = 1'b0;
    fault_clr_o = 1'b0;
    redir_acc_o = 1'b0;
    case (state_i)
      BOOT: begin
        // One settling cycle; an exception here still lands on the vector.
        state_d_o = RUN;
        if (exc_req_i) begin
          pc_d_o      = EXC_VECTOR;
          squash_o    = 1'b1;
          fault_clr_o = 1'b1;
        end
      end
      RUN: begin
        if (exc_req_i) begin
          pc_d_o      = EXC_VECTOR;
          squash_o    = 1'b1;
          fault_clr_o = 1'b1;
        end else if (redirect_i && is_misaligned(redirect_target_i)) begin
          state_d_o   = FAULT;
          squash_o    = 1'b1;
          fault_set_o = 1'b1;
        end else if (redirect_i) begin
          pc_d_o      = redirect_target_i;
          squash_o    = 1'b1;
          redir_acc_o = 1'b1;
        end else if (!stall_i) begin
          pc_d_o    = pc4_o;
          capture_o = 1'b1;
        end
      end
      FAULT: begin
        // Parked until the exception handler takes over.
        if (exc_req_i) begin
          state_d_o   = RUN;
          pc_d_o      = EXC_VECTOR;
          squash_o    = 1'b1;
          fault_clr_o = 1'b1;
        end
      end
      default: begin
        state_d_o = BOOT;
        squash_o  = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// IF stage: holds PC, fetches from combinational imem, fills the IF/ID register.
// One cycle fetch latency; one bubble per accepted redirect or exception.
// Stall holds PC and IF/ID; redirect/exception override stall; FAULT ignores both.
module instr_fetch_unit
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter logic [31:0] EXC_VECTOR = 32'hF000_0000
) (
  input  logic                  clk,
  input  logic                  reset,
  instr_fetch_unit_if.master    bus
);

  fetch_state_t state_q, state_d;
  logic [31:0]  pc_q, pc_d, pc4;
  ifid_t        ifid_q;
  logic         fault_q;
  logic [31:0]  fetch_cnt_q;
  logic [31:0]  redir_cnt_q;
  logic         capture, squash, fault_set, fault_clr, redir_acc;

  pc_next_sel #(
    .EXC_VECTOR (EXC_VECTOR)
  ) u_pc_next_sel (
    .state_i           (state_q),
    .pc_i              (pc_q),
    .stall_i           (bus.stall),
    .redirect_i        (bus.redirect),
    .redirect_target_i (bus.redirect_target),
    .exc_req_i         (bus.exc_req),
    .state_d_o         (state_d),
    .pc_d_o            (pc_d),
    .pc4_o             (pc4),
    .capture_o         (capture),
    .squash_o          (squash),
    .fault_set_o       (fault_set),
    .fault_clr_o       (fault_clr),
    .redir_acc_o       (redir_acc)
  );

  // Fetch FSM with its registered outputs: PC, IF/ID, fault flag and counters.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= BOOT;
      pc_q        <= RESET_PC;
      ifid_q      <= '{instr: NOP_INSTR, pc4: 32'h0, valid: 1'b0};
      fault_q     <= 1'b0;
      fetch_cnt_q <= 32'h0;
      redir_cnt_q <= 32'h0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      if (capture) begin
        // Memory word is taken as-is; unmapped addresses are not screened.
        ifid_q      <= '{instr: bus.imem_data, pc4: pc4, valid: 1'b1};
        fetch_cnt_q <= fetch_cnt_q + 32'd1;
      end else if (squash) begin
        // Wrong-path or stalled word becomes a bubble; payload left stale.
        ifid_q.valid <= 1'b0;
      end
      if (fault_clr) begin
        fault_q <= 1'b0;
      end else if (fault_set) begin
        fault_q <= 1'b1;
      end
      if (redir_acc) begin
        redir_cnt_q <= redir_cnt_q + 32'd1;
      end
    end
  end

  assign bus.imem_addr      = pc_q;
  assign bus.ifid_instr     = ifid_q.instr;
  assign bus.ifid_pc4       = ifid_q.pc4;
  assign bus.ifid_valid     = ifid_q.valid;
  assign bus.fetch_fault    = fault_q;
  assign bus.fetch_count    = fetch_cnt_q;
  assign bus.redirect_count = redir_cnt_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with a small instruction-memory model.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
// Expected values are hand-derived constants.
module tb_instr_fetch_unit;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_errors;

  instr_fetch_unit_if ifc ();

  instr_fetch_unit #(
    .RESET_PC   (32'h0000_0000),
    .EXC_VECTOR (32'hF000_0000)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (ifc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction memory model; unlisted addresses return a recognisable filler.
  function automatic logic [31:0] imem_word(input logic [31:0] a);
    case (a)
      32'h0000_0000: return 32'h3408_0032;
      32'h0000_0004: return 32'hAC08_0000;
      32'h0000_002C: return 32'h1145_0005;
      32'h0000_0190: return 32'hAC09_0054;
      32'hF000_0000: return 32'h8C08_0000;
      default:       return a ^ 32'h5A5A_0000;
    endcase
  endfunction

  always_comb ifc.imem_data = imem_word(ifc.imem_addr);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic tick_n(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    reset = 1'b1;
    ifc.stall = 1'b0;
    ifc.redirect = 1'b0;
    ifc.redirect_target = 32'h0;
    ifc.exc_req = 1'b0;

    // Reset values
    #1;
    check("rst_pc", ifc.imem_addr, 32'h0);
    check("rst_instr", ifc.ifid_instr, 32'h0);
    check("rst_pc4", ifc.ifid_pc4, 32'h0);
    check("rst_valid", {31'b0, ifc.ifid_valid}, 32'h0);
    check("rst_fault", {31'b0, ifc.fetch_fault}, 32'h0);
    check("rst_fcnt", ifc.fetch_count, 32'h0);
    check("rst_rcnt", ifc.redirect_count, 32'h0);
    tick();
    reset = 1'b0;

    // BOOT edge: no capture, PC held
    tick();
    check("boot_pc", ifc.imem_addr, 32'h0);
    check("boot_valid", {31'b0, ifc.ifid_valid}, 32'h0);
    tick();
    check("f1_instr", ifc.ifid_instr, 32'h3408_0032);
    check("f1_pc4", ifc.ifid_pc4, 32'h4);
    check("f1_valid", {31'b0, ifc.ifid_valid}, 32'h1);
    check("f1_fcnt", ifc.fetch_count, 32'd1);
    tick();
    check("f2_instr", ifc.ifid_instr, 32'hAC08_0000);
    check("f2_pc4", ifc.ifid_pc4, 32'h8);
    check("f2_fcnt", ifc.fetch_count, 32'd2);

    // Run to PC=0x2C, then stall three cycles
    tick_n(9);
    check("pre_stall_pc", ifc.imem_addr, 32'h2C);
    check("pre_stall_fcnt", ifc.fetch_count, 32'd11);
    ifc.stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_pc", ifc.imem_addr, 32'h2C);
      check("stall_pc4", ifc.ifid_pc4, 32'h2C);
      check("stall_instr", ifc.ifid_instr, 32'h28 ^ 32'h5A5A_0000);
      check("stall_fcnt", ifc.fetch_count, 32'd11);
    end
    ifc.stall = 1'b0;
    tick();
    check("unstall_instr", ifc.ifid_instr, 32'h1145_0005);
    check("unstall_pc4", ifc.ifid_pc4, 32'h30);
    check("unstall_fcnt", ifc.fetch_count, 32'd12);

    // Run to 0x188, redirect to 0x190
    tick_n(86);
    check("pre_redir_pc", ifc.imem_addr, 32'h188);
    ifc.redirect = 1'b1;
    ifc.redirect_target = 32'h190;
    tick();
    ifc.redirect = 1'b0;
    check("redir_valid", {31'b0, ifc.ifid_valid}, 32'h0);
    check("redir_pc", ifc.imem_addr, 32'h190);
    check("redir_fcnt", ifc.fetch_count, 32'd98);
    tick();
    check("tgt_instr", ifc.ifid_instr, 32'hAC09_0054);
    check("tgt_pc4", ifc.ifid_pc4, 32'h194);
    check("tgt_rcnt", ifc.redirect_count, 32'd1);

    // Misaligned redirect -> FAULT
    ifc.redirect = 1'b1;
    ifc.redirect_target = 32'h192;
    tick();
    check("flt_set", {31'b0, ifc.fetch_fault}, 32'h1);
    check("flt_valid", {31'b0, ifc.ifid_valid}, 32'h0);
    check("flt_pc", ifc.imem_addr, 32'h194);
    ifc.redirect_target = 32'h400;
    for (int i = 0; i < 4; i++) begin
      ifc.stall = i[0];
      ifc.redirect = ~i[1];
      tick();
      check("flt_hold_valid", {31'b0, ifc.ifid_valid}, 32'h0);
      check("flt_hold_pc", ifc.imem_addr, 32'h194);
      check("flt_hold_sticky", {31'b0, ifc.fetch_fault}, 32'h1);
    end
    check("flt_rcnt", ifc.redirect_count, 32'd1);
    ifc.stall = 1'b0;
    ifc.redirect = 1'b0;
    ifc.exc_req = 1'b1;
    tick();
    ifc.exc_req = 1'b0;
    check("exc_pc", ifc.imem_addr, 32'hF000_0000);
    check("exc_fault_clr", {31'b0, ifc.fetch_fault}, 32'h0);
    check("exc_valid", {31'b0, ifc.ifid_valid}, 32'h0);
    tick();
    check("vec_instr", ifc.ifid_instr, 32'h8C08_0000);
    check("vec_pc4", ifc.ifid_pc4, 32'hF000_0004);
    check("vec_valid", {31'b0, ifc.ifid_valid}, 32'h1);

    // Exception beats a simultaneous redirect
    ifc.exc_req = 1'b1;
    ifc.redirect = 1'b1;
    ifc.redirect_target = 32'h400;
    tick();
    ifc.exc_req = 1'b0;
    ifc.redirect = 1'b0;
    check("excw_pc", ifc.imem_addr, 32'hF000_0000);
    check("excw_rcnt", ifc.redirect_count, 32'd1);

    // Redirect under stall to the top word, then wrap
    ifc.stall = 1'b1;
    ifc.redirect = 1'b1;
    ifc.redirect_target = 32'hFFFF_FFFC;
    tick();
    ifc.stall = 1'b0;
    ifc.redirect = 1'b0;
    check("top_pc", ifc.imem_addr, 32'hFFFF_FFFC);
    check("top_valid", {31'b0, ifc.ifid_valid}, 32'h0);
    check("top_rcnt", ifc.redirect_count, 32'd2);
    tick();
    check("wrap_pc4", ifc.ifid_pc4, 32'h0);
    check("wrap_pc", ifc.imem_addr, 32'h0);
    check("wrap_instr", ifc.ifid_instr, 32'hFFFF_FFFC ^ 32'h5A5A_0000);
    tick();
    check("wrap_run_instr", ifc.ifid_instr, 32'h3408_0032);

    // Mid-run asynchronous reset
    #2;
    reset = 1'b1;
    #1;
    check("mrst_pc", ifc.imem_addr, 32'h0);
    check("mrst_valid", {31'b0, ifc.ifid_valid}, 32'h0);
    check("mrst_fcnt", ifc.fetch_count, 32'h0);
    check("mrst_rcnt", ifc.redirect_count, 32'h0);
    tick();
    reset = 1'b0;

    // Exception during BOOT still lands on the vector and proceeds to RUN
    ifc.exc_req = 1'b1;
    tick();
    ifc.exc_req = 1'b0;
    check("bexc_pc", ifc.imem_addr, 32'hF000_0000);
    check("bexc_valid", {31'b0, ifc.ifid_valid}, 32'h0);
    tick();
    check("bexc_instr", ifc.ifid_instr, 32'h8C08_0000);
    check("bexc_valid2", {31'b0, ifc.ifid_valid}, 32'h1);
    check("bexc_fcnt", ifc.fetch_count, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Instruction-fetch (IF) stage of the MIPS pipeline; the initiating side of the combinational instruction-memory interface. Holds the PC and drives the 32-bit fetch address to instruction memory. Captures the returned instruction word into the IF/ID pipeline register, and applies stall, control-flow redirect and exception-vector redirect from later stages. Sits between the instruction memory and the decode stage.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset.
- EXC_VECTOR, 32'hF000_0000, overflow-exception handler address.

Ports:
- clk  in  1  clock; all state updates on its rising edge.
- reset  in  1  reset; asynchronous and active-high.
- imem_addr  out  32  fetch address to instruction memory; equals the PC register.
- imem_data  in  32  instruction word from memory, valid in the same cycle as imem_addr.
- stall  in  1  decode/hazard stall; hold the PC and IF/ID.
- redirect  in  1  branch/jump/jr taken; load redirect_target.
- redirect_target  in  32  new PC when redirect=1.
- exc_req  in  1  exception; load EXC_VECTOR.
- ifid_instr  out  32  latched instruction.
- ifid_pc4  out  32  PC+4 of the latched instruction, used for branch/jal.
- ifid_valid  out  1  ifid_instr is a real instruction, not a bubble.
- fetch_fault  out  1  misaligned redirect target; sticky until exc_req.
- fetch_count  out  32  number of valid instructions latched.
- redirect_count  out  32  number of accepted redirects, for branch-prediction tests.

## Operation
FSM states:
- BOOT: entered on reset; lasts exactly one cycle, then moves to RUN. No capture into IF/ID; the PC is held.
- RUN: normal fetch.
- FAULT: ifid_valid=0; the PC is held; stall and redirect are ignored. Only exc_req leaves this state, going to RUN.

RUN, per-edge priority (highest first):
1. exc_req: PC ← EXC_VECTOR; ifid_valid ← 0; fetch_fault ← 0.
2. redirect with redirect_target[1:0] ≠ 0: enter FAULT; fetch_fault ← 1; ifid_valid ← 0; PC unchanged.
3. redirect, aligned target: PC ← redirect_target; ifid_valid ← 0 (squash wrong-path fetch); redirect_count += 1.
4. stall: PC, ifid_* and both counters hold.
5. Otherwise: ifid_instr ← imem_data; ifid_pc4 ← PC+4; ifid_valid ← 1; PC ← PC+4; fetch_count += 1.

Arithmetic and wrap rules:
- PC+4 is modulo 2^32, so 32'hFFFF_FFFC wraps to 0.
- Both counters wrap modulo 2^32.

Redirect during stall:
- Redirect overrides stall; the stalled IF/ID contents become a bubble.
- Decode must not assert stall and redirect for the same instruction in a way that expects the instruction to be kept.

imem_data unknown (unmapped address):
- No detection. The value is latched as-is.

exc_req in BOOT:
- The PC is loaded with EXC_VECTOR and the FSM still proceeds to RUN.

## Timing
Reset values (asynchronous assert, immediate effect):
- PC = RESET_PC
- ifid_instr = 0 (nop)
- ifid_pc4 = 0
- ifid_valid = 0
- fetch_fault = 0
- both counters = 0
- state = BOOT

Cycle-level behaviour:
- Release of reset is synchronous to clk.
- The first valid IF/ID appears 2 edges after reset deassertion (BOOT edge, then first capture).
- imem_addr is a register output; it changes only on clk edges or on reset.
- Fetch latency is one cycle: the word for PC at edge n appears on ifid_instr after edge n.
- Redirect penalty is one bubble: the target instruction is latched on the edge after the redirect edge.
- Reset asserted mid-operation immediately restores all reset values; any in-flight IF/ID is lost.

## Structure
Package `mips_pkg`:
- fetch_state_t enum (BOOT, RUN, FAULT).
- Constant NOP_INSTR = 32'h0000_0000.
- ifid_t struct {instr, pc4, valid}, shared with decode.

Sub-module `pc_next_sel`:
- Combinational priority mux producing next PC, capture enable, squash, and fault-detect signals.
- The top level holds the PC, IF/ID, FSM and counters.

## Test plan
Each scenario pairs the unit with the team's InstructionMemory model.
- Reset then free run: PC=0 for BOOT. After 2 edges, ifid_instr=34080032, ifid_pc4=4, valid=1. After the next edge, ac080000, pc4=8, fetch_count=2.
- Stall held for 3 cycles at PC=0x2C: imem_addr stays 0x2C, ifid_* unchanged, fetch_count unchanged. On release, 11450005 is latched.
- Redirect to 0x190 while PC=0x188: next edge gives ifid_valid=0 and imem_addr=0x190. The following edge gives ifid_instr=ac090054 and redirect_count=1.
- Redirect to 0x192: fetch_fault=1, state FAULT, ifid_valid stays 0 while stall and redirect toggle. Then exc_req gives PC=F000_0000, the next capture is 8c080000, and fetch_fault=0.
- exc_req and redirect(0x400) in the same cycle: PC becomes F000_0000 (exception wins) and redirect_count is unchanged.
- Redirect to FFFF_FFFC followed by a free run: ifid_pc4=0 and the PC wraps to 0. Reset asserted mid-run immediately gives PC=0, valid=0 and counters 0.
